// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: register index,
// hazard sequencer states and the per-cycle control word.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALTED
    } pctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic fd_flush;
        logic de_en;
        logic de_flush;
        logic em_en;
        logic em_flush;
        logic mw_en;
    } pctrl_word_t;

    localparam pctrl_word_t CW_IDLE = '{
        pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, de_en: 1'b0,
        de_flush: 1'b0, em_en: 1'b0, em_flush: 1'b0, mw_en: 1'b0
    };

    localparam pctrl_word_t CW_TAKE = '{
        pc_en: 1'b1, fd_en: 1'b0, fd_flush: 1'b1, de_en: 1'b0,
        de_flush: 1'b1, em_en: 1'b0, em_flush: 1'b1, mw_en: 1'b1
    };

    localparam pctrl_word_t CW_LOAD_USE = '{
        pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, de_en: 1'b0,
        de_flush: 1'b1, em_en: 1'b1, em_flush: 1'b0, mw_en: 1'b1
    };

    localparam pctrl_word_t CW_IMISS = '{
        pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b1, de_en: 1'b1,
        de_flush: 1'b0, em_en: 1'b1, em_flush: 1'b0, mw_en: 1'b1
    };

    localparam pctrl_word_t CW_RUN = '{
        pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b0, de_en: 1'b1,
        de_flush: 1'b0, em_en: 1'b1, em_flush: 1'b0, mw_en: 1'b1
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between execute-stage load and
// decode-stage sources; register 0 never hazards.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     exe_MemRd,
    input  regbits_t exe_rt,
    input  regbits_t dec_rs,
    input  regbits_t dec_rt,
    input  logic     dec_uses_rt,
    output logic     hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (exe_rt == dec_rs);
    assign rt_match = dec_uses_rt & (exe_rt == dec_rt);
    assign hazard   = exe_MemRd & (|exe_rt) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Define PIPE_CTRL_PERF_EN to add stall/flush performance counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     mem_MemRd,
    input  logic     mem_MemWr,
    input  logic     mem_take,
    input  logic     exe_MemRd,
    input  regbits_t exe_rt,
    input  regbits_t dec_rs,
    input  regbits_t dec_rt,
    input  logic     dec_uses_rt,
    input  logic     wb_halt,
    output logic     pc_EN,
    output logic     fd_EN,
    output logic     fd_flush,
    output logic     de_EN,
    output logic     de_flush,
    output logic     em_EN,
    output logic     em_flush,
    output logic     mw_EN,
    output logic     halted
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    pctrl_state_t state;
    pctrl_state_t state_nxt;
    pctrl_word_t  cw;

    logic hazard;
    logic dstall;
    logic active;
    logic p1, p2, p3, p4;
    logic r_halt, r_dwait, r_take, r_lu, r_miss, r_run;

    load_use_detect u_lud (
        .exe_MemRd  (exe_MemRd),
        .exe_rt     (exe_rt),
        .dec_rs     (dec_rs),
        .dec_rt     (dec_rt),
        .dec_uses_rt(dec_uses_rt),
        .hazard     (hazard)
    );

    // One-hot rule selects: each rule is masked by all higher ones
    assign dstall  = (mem_MemRd | mem_MemWr) & ~dhit;
    assign active  = ~RST & (state != HALTED);
    assign r_halt  = active & wb_halt;
    assign p1      = active & ~wb_halt;
    assign r_dwait = p1 & dstall;
    assign p2      = p1 & ~dstall;
    assign r_take  = p2 & mem_take;
    assign p3      = p2 & ~mem_take;
    assign r_lu    = p3 & hazard;
    assign p4      = p3 & ~hazard;
    assign r_miss  = p4 & ~ihit;
    assign r_run   = p4 & ihit;

    always_comb begin
        cw        = CW_IDLE;
        state_nxt = state;
        unique case (1'b1)
            r_halt: begin
                state_nxt = HALTED;
            end
            r_dwait: begin
                state_nxt = DWAIT;
            end
            r_take: begin
                cw        = CW_TAKE;
                state_nxt = RUN;
            end
            r_lu: begin
                cw        = CW_LOAD_USE;
                state_nxt = RUN;
            end
            r_miss: begin
                cw        = CW_IMISS;
                state_nxt = RUN;
            end
            r_run: begin
                cw        = CW_RUN;
                state_nxt = RUN;
            end
            default: begin
                cw        = CW_IDLE;
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign pc_EN    = cw.pc_en;
    assign fd_EN    = cw.fd_en;
    assign fd_flush = cw.fd_flush;
    assign de_EN    = cw.de_en;
    assign de_flush = cw.de_flush;
    assign em_EN    = cw.em_en;
    assign em_flush = cw.em_flush;
    assign mw_EN    = cw.mw_en;
    assign halted   = (state == HALTED) & ~RST;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (active && !cw.pc_en && stall_q != '1) begin
                stall_q <= stall_q + 32'd1;
            end
            if (r_take && flush_q != '1) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cycles = RST ? '0 : stall_q;
    assign flush_events = RST ? '0 : flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against
// a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic       CLK;
    logic       RST;
    logic       ihit, dhit, mem_MemRd, mem_MemWr, mem_take;
    logic       exe_MemRd, dec_uses_rt, wb_halt;
    logic [4:0] exe_rt, dec_rs, dec_rt;
    logic       pc_EN, fd_EN, fd_flush, de_EN, de_flush;
    logic       em_EN, em_flush, mw_EN, halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int total = 0;
    int bad   = 0;

    // Model: 0 = running, 1 = waiting on data, 2 = halted
    int          m_mode = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;

    logic [7:0] obs;
    assign obs = {pc_EN, fd_EN, fd_flush, de_EN,
                  de_flush, em_EN, em_flush, mw_EN};

    pipeline_hazard_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .mem_MemRd  (mem_MemRd),
        .mem_MemWr  (mem_MemWr),
        .mem_take   (mem_take),
        .exe_MemRd  (exe_MemRd),
        .exe_rt     (exe_rt),
        .dec_rs     (dec_rs),
        .dec_rt     (dec_rt),
        .dec_uses_rt(dec_uses_rt),
        .wb_halt    (wb_halt),
        .pc_EN      (pc_EN),
        .fd_EN      (fd_EN),
        .fd_flush   (fd_flush),
        .de_EN      (de_EN),
        .de_flush   (de_flush),
        .em_EN      (em_EN),
        .em_flush   (em_flush),
        .mw_EN      (mw_EN),
        .halted     (halted)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic load_use();
        if (!exe_MemRd || exe_rt == 5'd0) return 1'b0;
        if (exe_rt == dec_rs) return 1'b1;
        return dec_uses_rt && (exe_rt == dec_rt);
    endfunction

    function automatic logic data_wait();
        return (mem_MemRd || mem_MemWr) && !dhit;
    endfunction

    // Expected {pc,fdEN,fdFl,deEN,deFl,emEN,emFl,mw}
    function automatic logic [7:0] exp_ctrl();
        if (RST || m_mode == 2) return 8'b0000_0000;
        if (wb_halt)            return 8'b0000_0000;
        if (data_wait())        return 8'b0000_0000;
        if (mem_take)           return 8'b1010_1011;
        if (load_use())         return 8'b0000_1101;
        if (!ihit)              return 8'b0011_0101;
        return 8'b1101_0101;
    endfunction

    function automatic logic exp_halted();
        return (m_mode == 2) && !RST;
    endfunction

    task automatic tick();
        logic [7:0] e;
        int         nxt;
        logic       take_rule;
        e = exp_ctrl();
        take_rule = !RST && m_mode != 2 && !wb_halt
                    && !data_wait() && mem_take;
        if (RST)              nxt = 0;
        else if (m_mode == 2) nxt = 2;
        else if (wb_halt)     nxt = 2;
        else if (data_wait()) nxt = 1;
        else                  nxt = 0;
        @(posedge CLK);
        if (RST) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (m_mode != 2 && !e[7] && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;
            if (take_rule && m_flush != 32'hFFFF_FFFF)
                m_flush = m_flush + 1;
        end
        m_mode = nxt;
        #1;
    endtask

    task automatic quiet();
        RST = 0; ihit = 1; dhit = 1;
        mem_MemRd = 0; mem_MemWr = 0; mem_take = 0;
        exe_MemRd = 0; dec_uses_rt = 1; wb_halt = 0;
        exe_rt = 5'($urandom); dec_rs = 5'($urandom);
        dec_rt = 5'($urandom);
    endtask

    task automatic rand_in();
        ihit        = ($urandom % 4) != 0;
        dhit        = ($urandom % 3) != 0;
        mem_MemRd   = ($urandom % 4) == 0;
        mem_MemWr   = ($urandom % 6) == 0;
        mem_take    = ($urandom % 8) == 0;
        exe_MemRd   = 1'($urandom);
        dec_uses_rt = 1'($urandom);
        wb_halt     = ($urandom % 60) == 0;
        exe_rt      = 5'($urandom_range(0, 3));
        dec_rs      = 5'($urandom_range(0, 3));
        dec_rt      = 5'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rand_in();
            RST = 1;
            #2;
            total++;
            if (obs !== 8'h00 || halted !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc%0d ctrl=%b halted=%b want 00000000/0",
                         i, obs, halted);
            end
`ifdef PIPE_CTRL_PERF_EN
            total++;
            if (stall_cycles !== 0 || flush_events !== 0) begin
                bad++;
                $display("FAIL reset_perf got %0d/%0d want 0/0",
                         stall_cycles, flush_events);
            end
`endif
            tick();
        end
        quiet();
        #2;
        total++;
        if (obs !== 8'b1101_0101) begin
            bad++;
            $display("FAIL reset_release ctrl=%b want 11010101", obs);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [7:0] e;
        quiet();
        exe_MemRd = 1; exe_rt = 5'd8; dec_rs = 5'd8; dec_rt = 5'd3;
        #2;
        total++;
        if (obs !== 8'b0000_1101) begin
            bad++;
            $display("FAIL load_use ctrl=%b want 00001101", obs);
        end
        tick();
        // Load has moved to memory and completes this cycle
        quiet();
        mem_MemRd = 1; dhit = 1; dec_rs = 5'd8;
        #2;
        total++;
        if (obs !== 8'b1101_0101) begin
            bad++;
            $display("FAIL load_use_after ctrl=%b want 11010101", obs);
        end
        tick();
        quiet();
        exe_MemRd = 1; exe_rt = 5'd0; dec_rs = 5'd0; dec_rt = 5'd0;
        #2;
        total++;
        if (obs !== 8'b1101_0101) begin
            bad++;
            $display("FAIL load_use_r0 ctrl=%b want 11010101", obs);
        end
        tick();
        quiet();
        exe_MemRd = 1; exe_rt = 5'd8; dec_rs = 5'd3; dec_rt = 5'd8;
        dec_uses_rt = 0;
        #2;
        total++;
        if (obs !== 8'b1101_0101) begin
            bad++;
            $display("FAIL load_use_rt_unused ctrl=%b want 11010101", obs);
        end
        tick();
        dec_uses_rt = 1;
        #2;
        e = exp_ctrl();
        total++;
        if (obs !== e || e !== 8'b0000_1101) begin
            bad++;
            $display("FAIL load_use_rt ctrl=%b want 00001101", obs);
        end
        tick();
    endtask

    task automatic test_dwait();
        logic [31:0] s0;
        quiet();
        s0 = m_stall;
        for (int i = 0; i < 3; i++) begin
            mem_MemRd = 1; dhit = 0; ihit = 1'($urandom);
            #2;
            total++;
            if (obs !== 8'h00) begin
                bad++;
                $display("FAIL dwait cyc%0d ctrl=%b want 00000000", i, obs);
            end
            tick();
        end
        dhit = 1; ihit = 1;
        #2;
        total++;
        if (obs !== 8'b1101_0101) begin
            bad++;
            $display("FAIL dwait_done ctrl=%b want 11010101", obs);
        end
        tick();
`ifdef PIPE_CTRL_PERF_EN
        total++;
        if (stall_cycles !== m_stall || m_stall - s0 !== 32'd3) begin
            bad++;
            $display("FAIL dwait_stalls got %0d want %0d", stall_cycles, m_stall);
        end
`endif
        quiet();
    endtask

    task automatic test_branch();
        logic [31:0] f0;
        quiet();
        f0 = m_flush;
        mem_take = 1; exe_MemRd = 1; exe_rt = 5'd8; dec_rs = 5'd8;
        #2;
        total++;
        if (obs !== 8'b1010_1011) begin
            bad++;
            $display("FAIL branch ctrl=%b want 10101011", obs);
        end
        tick();
        quiet();
        #2;
`ifdef PIPE_CTRL_PERF_EN
        total++;
        if (flush_events !== m_flush || m_flush - f0 !== 32'd1) begin
            bad++;
            $display("FAIL branch_flushes got %0d want %0d", flush_events, m_flush);
        end
`endif
        tick();
    endtask

    task automatic test_fetch_miss();
        quiet();
        for (int i = 0; i < 2; i++) begin
            ihit = 0;
            #2;
            total++;
            if (obs !== 8'b0011_0101) begin
                bad++;
                $display("FAIL fetch_miss cyc%0d ctrl=%b want 00110101", i, obs);
            end
            tick();
        end
        quiet();
        tick();
    endtask

    task automatic test_halt();
        quiet();
        wb_halt = 1; mem_MemRd = 1; dhit = 0;
        #2;
        total++;
        if (obs !== 8'h00 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_entry ctrl=%b halted=%b want 00000000/0",
                     obs, halted);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            rand_in();
            #2;
            total++;
            if (obs !== 8'h00 || halted !== 1'b1) begin
                bad++;
                $display("FAIL halt_hold cyc%0d ctrl=%b halted=%b want 00000000/1",
                         i, obs, halted);
            end
            tick();
        end
        RST = 1;
        #2;
        total++;
        if (halted !== 1'b0 || obs !== 8'h00) begin
            bad++;
            $display("FAIL halt_reset halted=%b ctrl=%b want 0/00000000",
                     halted, obs);
        end
        tick();
        quiet();
        #2;
        total++;
        if (obs !== 8'b1101_0101 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_exit ctrl=%b halted=%b want 11010101/0",
                     obs, halted);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int i = 0; i < 400; i++) begin
            rand_in();
            RST = ($urandom % 50) == 0;
            #2;
            e = exp_ctrl();
            total++;
            if (obs !== e || halted !== exp_halted()) begin
                bad++;
                $display("FAIL random cyc%0d ctrl=%b halted=%b want %b/%b",
                         i, obs, halted, e, exp_halted());
            end
`ifdef PIPE_CTRL_PERF_EN
            total++;
            if (stall_cycles !== m_stall || flush_events !== m_flush) begin
                bad++;
                $display("FAIL random_perf cyc%0d got %0d/%0d want %0d/%0d",
                         i, stall_cycles, flush_events, m_stall, m_flush);
            end
`endif
            tick();
        end
    endtask

    initial begin
        quiet();
        @(posedge CLK);
        #1;
        test_reset();
        test_load_use();
        test_dwait();
        test_branch();
        test_fetch_miss();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
